// File: rtl/sfp_acc_array.sv
// sfp_acc_array: per-column psum accumulator; sums col-wide beats into depth entries
//   over npass passes, then drains entries with optional ReLU and signed saturation.
// Latency: last input beat in cycle k -> first out_valid in k+1; done one cycle after
//   the last drain handshake. Backpressure: in_ready only in ACC; DRAIN holds
//   out_data stable until out_ready.
// Ports:
//   clk, reset (async, active-low)       clock and reset
//   start, cfg_nent, cfg_npass, cfg_relu job launch and config, sampled in IDLE only
//   in_valid/in_ready/in_data            psum beats from OFIFO, lane i at [psum_bw*i +: psum_bw]
//   out_valid/out_ready/out_data         drained entries toward PMEM, same lane packing
//   busy, done, ovf                      job status; ovf is sticky per job
module sfp_acc_array #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 16,
   parameter int aw      = $clog2(depth)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [aw:0]              cfg_nent,
   input  logic [7:0]               cfg_npass,
   input  logic                     cfg_relu,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [psum_bw*col-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [psum_bw*col-1:0]   out_data,
   output logic                     busy,
   output logic                     done,
   output logic                     ovf
);

   localparam int dw = psum_bw * col;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACC   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [dw-1:0]     mem [depth];
   logic [aw:0]       nent;
   logic [7:0]        npass;
   logic              relu;
   logic [aw-1:0]     wr_ptr;
   logic [aw-1:0]     rd_ptr;
   logic [7:0]        pass_cnt;

   // Clamped configuration seen at start
   logic [aw:0]       nent_cfg;
   logic [7:0]        npass_cfg;

   always_comb begin
      nent_cfg = cfg_nent;
      if (cfg_nent == '0)
         nent_cfg = (aw+1)'(1);
      else if (cfg_nent > (aw+1)'(depth))
         nent_cfg = (aw+1)'(depth);
      npass_cfg = (cfg_npass == 8'd0) ? 8'd1 : cfg_npass;
   end

   // Pointer / pass boundary detection
   logic [aw:0]       last_ent;
   logic              wr_last;
   logic              rd_last;
   logic              pass_last;
   logic              beat;
   logic              out_hs;
   logic [aw-1:0]     rd_next;

   assign last_ent  = nent - (aw+1)'(1);
   assign wr_last   = ({1'b0, wr_ptr} == last_ent);
   assign rd_last   = ({1'b0, rd_ptr} == last_ent);
   assign pass_last = (pass_cnt == npass - 8'd1);
   assign beat      = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;
   assign rd_next   = rd_ptr + aw'(1);

   // Lane-wise write value: first pass overwrites, later passes saturating-add
   logic [dw-1:0]        cur_row;
   logic [dw-1:0]        new_row;
   logic                 sat_any;
   logic [psum_bw-1:0]   lane_a;
   logic [psum_bw-1:0]   lane_b;
   logic [psum_bw:0]     lane_s;

   localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
   localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

   assign cur_row = mem[wr_ptr];

   always_comb begin
      new_row = '0;
      sat_any = 1'b0;
      lane_a  = '0;
      lane_b  = '0;
      lane_s  = '0;
      for (int i = 0; i < col; i++) begin
         lane_a = cur_row[i*psum_bw +: psum_bw];
         lane_b = in_data[i*psum_bw +: psum_bw];
         // One extra bit of sign extension catches overflow in either direction
         lane_s = {lane_a[psum_bw-1], lane_a} + {lane_b[psum_bw-1], lane_b};
         if (pass_cnt == 8'd0) begin
            new_row[i*psum_bw +: psum_bw] = lane_b;
         end else if (lane_s[psum_bw] != lane_s[psum_bw-1]) begin
            new_row[i*psum_bw +: psum_bw] = lane_s[psum_bw] ? lane_min : lane_max;
            sat_any = 1'b1;
         end else begin
            new_row[i*psum_bw +: psum_bw] = lane_s[psum_bw-1:0];
         end
      end
   end

   // Zero negative lanes when ReLU is enabled for this job
   function automatic logic [dw-1:0] relu_row(input logic [dw-1:0] row, input logic en);
      logic [dw-1:0] r;
      r = row;
      for (int i = 0; i < col; i++) begin
         if (en && row[i*psum_bw + psum_bw - 1])
            r[i*psum_bw +: psum_bw] = '0;
      end
      return r;
   endfunction

   // Entry 0 presented on the first drain cycle. When nent==1 the final beat is
   // writing entry 0 in the same cycle, so forward the freshly computed row.
   logic [dw-1:0] first_row;
   logic [dw-1:0] next_row;

   assign first_row = (wr_ptr == '0) ? new_row : mem[0];
   assign next_row  = mem[rd_next];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         nent      <= (aw+1)'(1);
         npass     <= 8'd1;
         relu      <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         pass_cnt  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         ovf       <= 1'b0;
         for (int e = 0; e < depth; e++)
            mem[e] <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  nent     <= nent_cfg;
                  npass    <= npass_cfg;
                  relu     <= cfg_relu;
                  wr_ptr   <= '0;
                  rd_ptr   <= '0;
                  pass_cnt <= '0;
                  ovf      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= S_ACC;
               end
            end

            S_ACC: begin
               if (beat) begin
                  mem[wr_ptr] <= new_row;
                  if (sat_any)
                     ovf <= 1'b1;
                  if (wr_last) begin
                     wr_ptr <= '0;
                     if (pass_last) begin
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= relu_row(first_row, relu);
                        rd_ptr    <= '0;
                        state     <= S_DRAIN;
                     end else begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end else begin
                     wr_ptr <= wr_ptr + aw'(1);
                  end
               end
            end

            S_DRAIN: begin
               // out_data only moves on a handshake, so it is stable under stall
               if (out_hs) begin
                  if (rd_last) begin
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     rd_ptr    <= '0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     rd_ptr   <= rd_next;
                     out_data <= relu_row(next_row, relu);
                  end
               end
            end

            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sfp_acc_array.sv
// tb_sfp_acc_array: directed checks of sfp_acc_array (accumulate, saturate, ReLU,
//   back-pressure, config clamping, reset abort, pointer wrap).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sfp_acc_array;

   localparam int COL = 8;
   localparam int PSW = 16;
   localparam int DEP = 16;
   localparam int AW  = $clog2(DEP);
   localparam int DW  = COL * PSW;

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic [AW:0]     cfg_nent;
   logic [7:0]      cfg_npass;
   logic            cfg_relu;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            busy;
   logic            done;
   logic            ovf;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int done_cnt = 0;

   sfp_acc_array #(.col(COL), .psum_bw(PSW), .depth(DEP)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .cfg_nent  (cfg_nent),
      .cfg_npass (cfg_npass),
      .cfg_relu  (cfg_relu),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (reset && in_valid && in_ready) acc_cnt++;
   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] rep(input int v);
      logic [DW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*PSW +: PSW] = 16'(v);
      return r;
   endfunction

   function automatic logic [DW-1:0] mk2(input int a, input int b);
      logic [DW-1:0] r;
      r = '0;
      r[0 +: PSW]   = 16'(a);
      r[PSW +: PSW] = 16'(b);
      return r;
   endfunction

   function automatic logic [DW-1:0] bp_dat(input int e, input int p);
      logic [DW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*PSW +: PSW] = 16'(e*16 + i + p*100);
      return r;
   endfunction

   task automatic do_start(input int n, input int p, input logic rl, input string tag);
      @(negedge clk);
      start = 1'b1; cfg_nent = (AW+1)'(n); cfg_npass = 8'(p); cfg_relu = rl;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_inrdy"}, in_ready, 1'b1);
   endtask

   // Caller is on a falling edge; returns on the falling edge after acceptance
   task automatic send(input logic [DW-1:0] d, input int gap, input string tag);
      int n;
      repeat (gap) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1; in_data = d;
      n = 0;
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) begin
         chk({tag, "_acc_timeout"}, in_ready, 1'b1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic recv(input logic [DW-1:0] exp, input int stall, input string tag);
      logic [DW-1:0] held;
      int n;
      out_ready = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      if (!out_valid) begin
         chk({tag, "_out_timeout"}, out_valid, 1'b1);
         return;
      end
      held = out_data;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk({tag, "_hold"}, out_data, held);
      end
      chk(tag, out_data, exp);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      int base;
      int ov_seen;
      int dsave;
      reset = 1'b0; start = 1'b0; cfg_nent = '0; cfg_npass = '0; cfg_relu = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_out_data", out_data, '0);

      // Basic accumulation: 4 entries x 3 passes of 1..4
      do_start(4, 3, 1'b0, "t1");
      for (int p = 0; p < 3; p++)
         for (int e = 0; e < 4; e++) send(rep(e + 1), 0, "t1_in");
      chk("t1_first_valid", out_valid, 1'b1);
      for (int e = 0; e < 4; e++) recv(rep(3 * (e + 1)), 0, $sformatf("t1_e%0d", e));
      chk("t1_done", done, 1'b1);
      chk("t1_busy_off", busy, 1'b0);
      chk("t1_ovf", ovf, 1'b0);

      // Saturation with ReLU, then without
      do_start(1, 2, 1'b1, "t2a");
      send(mk2(30000, -30000), 0, "t2a_in");
      send(mk2(30000, -30000), 0, "t2a_in");
      recv(mk2(32767, 0), 0, "t2a_relu");
      chk("t2a_done", done, 1'b1);
      chk("t2a_ovf", ovf, 1'b1);
      do_start(1, 2, 1'b0, "t2b");
      chk("t2b_ovf_clr", ovf, 1'b0);
      send(mk2(30000, -30000), 0, "t2b_in");
      send(mk2(30000, -30000), 0, "t2b_in");
      recv(mk2(32767, -32768), 0, "t2b_norelu");
      chk("t2b_ovf", ovf, 1'b1);

      // Back-pressure: random gaps both sides, upstream keeps offering during drain
      base = acc_cnt;
      do_start(8, 2, 1'b0, "t3");
      for (int p = 0; p < 2; p++)
         for (int e = 0; e < 8; e++) send(bp_dat(e, p), $urandom_range(0, 2), "t3_in");
      in_valid = 1'b1; in_data = rep(999);
      for (int e = 0; e < 8; e++)
         recv(bp_dat(e, 0) + bp_dat(e, 1), $urandom_range(0, 3), $sformatf("t3_e%0d", e));
      chk("t3_done", done, 1'b1);
      repeat (3) @(negedge clk);
      chk("t3_beats", 32'(acc_cnt - base), 32'd16);
      in_valid = 1'b0;

      // Clamping: 0/0 behaves as 1/1; ovf clear after previous overflow job
      do_start(0, 0, 1'b0, "t4a");
      send(rep(7), 0, "t4a_in");
      recv(rep(7), 0, "t4a_out");
      chk("t4a_done", done, 1'b1);
      chk("t4a_ovf", ovf, 1'b0);

      // nent=31 clamps to 16; a start mid-ACC with other config is ignored
      do_start(31, 1, 1'b0, "t4b");
      for (int e = 0; e < 16; e++) begin
         send(rep(e - 8), 0, "t4b_in");
         if (e == 3) begin
            start = 1'b1; cfg_nent = 5'd2; cfg_npass = 8'd5; cfg_relu = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      for (int e = 0; e < 16; e++) recv(rep(e - 8), 0, $sformatf("t4b_e%0d", e));
      chk("t4b_done", done, 1'b1);

      // Reset during drain after 2 of 4 outputs
      do_start(4, 1, 1'b0, "t5");
      for (int e = 0; e < 4; e++) send(rep(e + 1), 0, "t5_in");
      recv(rep(1), 0, "t5_e0");
      recv(rep(2), 0, "t5_e1");
      reset = 1'b0;
      #1;
      chk("t5_rst_out_valid", out_valid, 1'b0);
      chk("t5_rst_out_data", out_data, '0);
      chk("t5_rst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      dsave = done_cnt;
      ov_seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) ov_seen = 1;
      end
      chk("t5_no_out", 32'(ov_seen), 32'd0);
      chk("t5_no_done", 32'(done_cnt - dsave), 32'd0);
      do_start(4, 2, 1'b0, "t5b");
      for (int e = 0; e < 4; e++) send(rep(10 + e), 0, "t5b_in");
      for (int e = 0; e < 4; e++) send(rep(e), 0, "t5b_in");
      for (int e = 0; e < 4; e++) recv(rep(10 + 2 * e), 0, $sformatf("t5b_e%0d", e));

      // Wrap: full depth, 4 passes of lane value = entry index
      do_start(16, 4, 1'b0, "t6");
      for (int p = 0; p < 4; p++)
         for (int e = 0; e < 16; e++) send(rep(e), 0, "t6_in");
      for (int e = 0; e < 16; e++) recv(rep(4 * e), 0, $sformatf("t6_e%0d", e));
      chk("t6_done", done, 1'b1);
      chk("t6_ovf", ovf, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfp_acc_array.md
# sfp_acc_array

Parametrised successor to the per-column SFP stage. It accepts `col`-wide psum vectors from the OFIFO read side over a valid/ready handshake. It accumulates them into a `depth`-entry buffer per column across a configurable number of passes, then drains the results with optional ReLU and signed saturation. It sits between the corelet OFIFO output and the PMEM write path, so partial sums for up to `depth` output pixels stay on-chip instead of round-tripping through PMEM.

## Interface
- `col`, 8, number of lanes (one per MAC-array column)
- `psum_bw`, 16, signed width of each lane's input, stored entry and output
- `depth`, 16, accumulation entries per lane; power of 2, ≥2
- `aw`, `$clog2(depth)`, entry address width (derived)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `start`  in  1  one-cycle job start; honoured only in IDLE
- `cfg_nent`  in  aw+1  entries used per pass; sampled at start; 0→1, >depth→depth
- `cfg_npass`  in  8  accumulation passes; sampled at start; 0→1
- `cfg_relu`  in  1  apply ReLU on drain; sampled at start
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block accepts a beat
- `in_data`  in  psum_bw*col  lane i at bits [psum_bw*(i+1)-1 : psum_bw*i]
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accepts
- `out_data`  out  psum_bw*col  drained entry, same lane packing
- `busy`  out  1  job in progress (ACC or DRAIN)
- `done`  out  1  one-cycle pulse, job complete
- `ovf`  out  1  sticky: any lane saturated during the current job; cleared at start

## Operation
- States: IDLE, ACC, DRAIN.
- **IDLE**
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 latches the clamped config, clears `wr_ptr`, `pass_cnt`, `rd_ptr` and `ovf`, and goes to ACC.
- **ACC**
  - `in_ready`=1.
  - Each accepted beat (`in_valid && in_ready`) with `pass_cnt==0` writes `in_data` into entry[`wr_ptr`]; the prior content is discarded. There is no separate clear phase.
  - Each accepted beat with `pass_cnt>0` adds `in_data` lane-wise to entry[`wr_ptr`] as a signed add.
  - Sum saturation: above +2^(psum_bw-1)-1 clamps to the max; below -2^(psum_bw-1) clamps to the min. Either case sets `ovf`.
  - `wr_ptr` increments per beat. It wraps to 0 after `nent`-1 and `pass_cnt` increments.
  - When the beat at `wr_ptr==nent-1` with `pass_cnt==npass-1` is accepted, go to DRAIN.
- **DRAIN**
  - `in_ready`=0.
  - `out_valid`=1 and `out_data` = entry[`rd_ptr`], with ReLU applied per lane when latched `cfg_relu`=1 (negative → 0).
  - A handshake (`out_valid && out_ready`) increments `rd_ptr`.
  - The handshake at `rd_ptr==nent-1` returns the block to IDLE and pulses `done`.
- `out_data` stays stable while `out_valid && !out_ready`.
- `start` outside IDLE is ignored. Config changes outside IDLE have no effect.
- `in_valid` in IDLE or DRAIN is not accepted. Upstream must hold the beat.
- Entries not addressed in a job (index ≥ `nent`) are neither written nor read.

## Timing
- Reset values:
  - state IDLE, all pointers and counters 0, all entries 0.
  - `in_ready`, `out_valid`, `busy`, `done` and `ovf` = 0.
  - `out_data` = 0.
- Reset mid-job aborts immediately. No `done` is produced and no partial output appears after release.
- `start` sampled high in cycle t → `busy`=1 and `in_ready`=1 in cycle t+1.
- Throughput is 1 beat/cycle in ACC and 1 entry/cycle in DRAIN when `out_ready`=1.
- Last input beat accepted in cycle k → `out_valid`=1 in k+1, presenting entry 0. Read-after-write is resolved internally, including `nent`=1.
- Last output handshake in cycle m → `done`=1 and `busy`=0 in m+1, ready for `start` in m+1.
- `ovf` updates in the cycle after the saturating beat and holds until the next accepted `start`.
- Minimum job latency is `nent*npass` + `nent` + 1 cycles with no back-pressure.

## Test plan
- **Basic accumulation.** depth=16, nent=4, npass=3, relu=0; feed lane values 1,2,3,4 per entry each pass. Expect drain of 3,6,9,12 on every lane, `done` one cycle after the 4th handshake, `ovf`=0.
- **Saturation and ReLU.** psum_bw=16, nent=1, npass=2; feed lane0 = 30000 then 30000, lane1 = -30000 then -30000, relu=1.
  - Expect lane0 = 32767 and lane1 = 0 (ReLU of -32768).
  - Expect `ovf`=1.
  - With relu=0, expect lane1 = -32768.
- **Back-pressure.** Random `in_valid` and `out_ready` gaps, nent=8, npass=2.
  - Results must match the gap-free run.
  - `out_data` must be stable across every stalled cycle.
  - No beats are accepted in IDLE or DRAIN.
- **Config clamping and start-while-busy.**
  - nent=0, npass=0 behaves as 1/1.
  - nent=31 with depth=16 behaves as 16.
  - A `start` pulse mid-ACC changes nothing.
  - A second job reports `ovf`=0 after a prior overflow job.
- **Reset mid-operation.** Assert `reset`=0 during DRAIN after 2 of 4 outputs.
  - All outputs are 0 immediately.
  - After release, no `out_valid` or `done` appears until a new `start`.
  - A fresh job then produces correct sums with no stale entries.
- **Wrap boundary.** nent=depth=16, npass=4, lane value = entry index. Expect drain 0,4,8,…,60 in order, and `rd_ptr`/`wr_ptr` wrap with no skipped or repeated entry.
